// File: rtl/spi_seq_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the spi_top transfer sequencer: register map,
// CTRL bit positions, FSM state encoding and the CTRL word builder.
package spi_seq_pkg;

    localparam logic [4:0] REG_RX0  = 5'h00;
    localparam logic [4:0] REG_TX0  = 5'h00;
    localparam logic [4:0] REG_CTRL = 5'h10;
    localparam logic [4:0] REG_DIV  = 5'h14;
    localparam logic [4:0] REG_SS   = 5'h18;

    localparam int CTRL_GO_BSY = 8;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_ASS    = 13;

    typedef enum logic [3:0] {
        ST_IDLE_CFG,
        ST_IDLE,
        ST_WR_SS,
        ST_WR_TX,
        ST_WR_CTRL,
        ST_WR_GO,
        ST_POLL,
        ST_WAIT_IRQ,
        ST_IRQ_CLR,
        ST_RD_RX,
        ST_RESP
    } seq_state_t;

    // Flags land on bits [15:9]; the two top flag bits are expected to be 0.
    function automatic logic [31:0] ctrl_word(input logic [6:0] flags,
                                              input logic [6:0] len,
                                              input logic       go);
        logic [31:0] w;
        w = (32'(flags) << CTRL_RX_NEG) | 32'(len);
        w[CTRL_GO_BSY] = go;
        return w;
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
`timescale 1ns/1ps
// Request/response channel and Wishbone bus bundles used by spi_xfer_sequencer.

interface spi_seq_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [6:0]  req_len;
    logic [7:0]  req_ss;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (output req_valid, req_data, req_len, req_ss, rsp_ready,
                    input  req_ready, rsp_valid, rsp_data, rsp_err);
    modport slave  (input  req_valid, req_data, req_len, req_ss, rsp_ready,
                    output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

interface spi_seq_wb_if;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_int_i;

    modport master (output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
                    input  wb_dat_i, wb_ack_i, wb_err_i, wb_int_i);
    modport slave  (input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
                    output wb_dat_i, wb_ack_i, wb_err_i, wb_int_i);
endinterface

// File: rtl/spi_seq_wb_port.sv
`timescale 1ns/1ps
// Single-operation classic Wishbone engine. A start on the terminating cycle
// of the previous op chains the next op with no idle gap (2 clocks per op).
module spi_seq_wb_port (
    input  logic         clk_tb,
    input  logic         reset_tb,
    spi_seq_wb_if.master wb,
    input  logic         start,
    input  logic [4:0]   addr,
    input  logic [31:0]  wdata,
    input  logic         we,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [31:0]  rdata
);
    logic        cyc_reg;
    logic        we_reg;
    logic [4:0]  adr_reg;
    logic [31:0] dat_reg;
    logic        term;

    assign term = cyc_reg & (wb.wb_ack_i | wb.wb_err_i);

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            cyc_reg <= 1'b0;
            we_reg  <= 1'b0;
            adr_reg <= '0;
            dat_reg <= '0;
        end else if (start && (!cyc_reg || term)) begin
            cyc_reg <= 1'b1;
            we_reg  <= we;
            adr_reg <= addr;
            dat_reg <= wdata;
        end else if (term) begin
            cyc_reg <= 1'b0;
            we_reg  <= 1'b0;
            adr_reg <= '0;
            dat_reg <= '0;
        end
    end

    assign wb.wb_cyc_o = cyc_reg;
    assign wb.wb_stb_o = cyc_reg;
    assign wb.wb_we_o  = we_reg;
    assign wb.wb_adr_o = adr_reg;
    assign wb.wb_dat_o = dat_reg;
    assign wb.wb_sel_o = cyc_reg ? 4'hF : 4'h0;

    assign busy  = cyc_reg;
    assign done  = cyc_reg & wb.wb_ack_i & ~wb.wb_err_i;
    assign err   = cyc_reg & wb.wb_err_i;
    assign rdata = wb.wb_dat_i;

endmodule

// File: rtl/spi_xfer_sequencer.sv
`timescale 1ns/1ps
// Drives spi_top through one SPI transfer per request: SS, TX0, CTRL, CTRL|GO,
// completion wait, RX0 read. Define SPI_SEQ_IRQ_EN to wait on wb_int_i instead of polling.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [15:0] DIVIDER    = 16'd1,
    parameter logic [6:0]  CTRL_FLAGS = 7'b0000000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic          clk_tb,
    input  logic          reset_tb,
    spi_seq_req_if.slave  req_bus,
    spi_seq_wb_if.master  wb
);
    localparam int CW = $clog2(POLL_LIMIT + 1);

`ifdef SPI_SEQ_IRQ_EN
    localparam logic [6:0] FLAGS_EFF = CTRL_FLAGS | 7'(1 << (CTRL_IE - CTRL_RX_NEG));
`else
    localparam logic [6:0] FLAGS_EFF = CTRL_FLAGS;
    logic unused_int;
    assign unused_int = wb.wb_int_i;
`endif

    seq_state_t  state_reg, state_next;
    logic        cfg_done_reg, cfg_done_next;
    logic [31:0] req_data_reg, req_data_next;
    logic [6:0]  req_len_reg, req_len_next;
    logic [7:0]  req_ss_reg, req_ss_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic        rsp_err_reg, rsp_err_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic [CW-1:0] poll_cnt_reg, poll_cnt_next, poll_cnt_inc;

    logic        op_start, op_we, op_busy, op_done, op_err;
    logic [4:0]  op_addr;
    logic [31:0] op_wdata, op_rdata;
    logic        req_ready_int;

    spi_seq_wb_port u_port (
        .clk_tb   (clk_tb),
        .reset_tb (reset_tb),
        .wb       (wb),
        .start    (op_start),
        .addr     (op_addr),
        .wdata    (op_wdata),
        .we       (op_we),
        .busy     (op_busy),
        .done     (op_done),
        .err      (op_err),
        .rdata    (op_rdata)
    );

    assign req_ready_int     = (state_reg == ST_IDLE) && cfg_done_reg && !rsp_valid_reg;
    assign req_bus.req_ready = req_ready_int;
    assign req_bus.rsp_valid = rsp_valid_reg;
    assign req_bus.rsp_err   = rsp_err_reg;
    assign req_bus.rsp_data  = rsp_data_reg;

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            state_reg     <= ST_IDLE_CFG;
            cfg_done_reg  <= 1'b0;
            req_data_reg  <= '0;
            req_len_reg   <= '0;
            req_ss_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= '0;
            poll_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cfg_done_reg  <= cfg_done_next;
            req_data_reg  <= req_data_next;
            req_len_reg   <= req_len_next;
            req_ss_reg    <= req_ss_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_data_reg  <= rsp_data_next;
            poll_cnt_reg  <= poll_cnt_next;
        end
    end

    // Each op is launched on the same edge that enters the state naming it,
    // so the state always describes the op currently on the bus.
    always_comb begin
        state_next     = state_reg;
        cfg_done_next  = cfg_done_reg;
        req_data_next  = req_data_reg;
        req_len_next   = req_len_reg;
        req_ss_next    = req_ss_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_data_next  = rsp_data_reg;
        poll_cnt_next  = poll_cnt_reg;
        poll_cnt_inc   = poll_cnt_reg + CW'(1);
        op_start       = 1'b0;
        op_addr        = REG_CTRL;
        op_wdata       = '0;
        op_we          = 1'b0;

        case (state_reg)
            ST_IDLE_CFG: begin
                if (!op_busy) begin
                    op_start = 1'b1;
                    op_addr  = REG_DIV;
                    op_wdata = {16'h0000, DIVIDER};
                    op_we    = 1'b1;
                end else if (op_err) begin
                    state_next = ST_IDLE;
                end else if (op_done) begin
                    cfg_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (!cfg_done_reg) begin
                    state_next = ST_IDLE_CFG;
                end else if (req_bus.req_valid && req_ready_int) begin
                    req_data_next = req_bus.req_data;
                    req_len_next  = req_bus.req_len;
                    req_ss_next   = req_bus.req_ss;
                    op_start      = 1'b1;
                    op_addr       = REG_SS;
                    op_wdata      = {24'h000000, req_bus.req_ss};
                    op_we         = 1'b1;
                    state_next    = ST_WR_SS;
                end
            end

            ST_RESP: begin
                if (req_bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    poll_cnt_next  = '0;
                    state_next     = cfg_done_reg ? ST_IDLE : ST_IDLE_CFG;
                end
            end

`ifdef SPI_SEQ_IRQ_EN
            ST_WAIT_IRQ: begin
                if (wb.wb_int_i) begin
                    op_start   = 1'b1;
                    op_addr    = REG_CTRL;
                    state_next = ST_IRQ_CLR;
                end else if (poll_cnt_inc == CW'(POLL_LIMIT)) begin
                    poll_cnt_next  = poll_cnt_inc;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_data_next  = '0;
                    state_next     = ST_RESP;
                end else begin
                    poll_cnt_next = poll_cnt_inc;
                end
            end
`endif

            default: begin
                if (op_err) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_data_next  = '0;
                    state_next     = ST_RESP;
                end else if (op_done) begin
                    case (state_reg)
                        ST_WR_SS: begin
                            op_start   = 1'b1;
                            op_addr    = REG_TX0;
                            op_wdata   = req_data_reg;
                            op_we      = 1'b1;
                            state_next = ST_WR_TX;
                        end
                        ST_WR_TX: begin
                            op_start   = 1'b1;
                            op_wdata   = ctrl_word(FLAGS_EFF, req_len_reg, 1'b0);
                            op_we      = 1'b1;
                            state_next = ST_WR_CTRL;
                        end
                        ST_WR_CTRL: begin
                            op_start   = 1'b1;
                            op_wdata   = ctrl_word(FLAGS_EFF, req_len_reg, 1'b1);
                            op_we      = 1'b1;
                            state_next = ST_WR_GO;
                        end
                        ST_WR_GO: begin
`ifdef SPI_SEQ_IRQ_EN
                            state_next = ST_WAIT_IRQ;
`else
                            op_start   = 1'b1;
                            state_next = ST_POLL;
`endif
                        end
                        ST_POLL: begin
                            if (!op_rdata[CTRL_GO_BSY]) begin
                                op_start   = 1'b1;
                                op_addr    = REG_RX0;
                                state_next = ST_RD_RX;
                            end else if (poll_cnt_inc == CW'(POLL_LIMIT)) begin
                                poll_cnt_next  = poll_cnt_inc;
                                rsp_valid_next = 1'b1;
                                rsp_err_next   = 1'b1;
                                rsp_data_next  = '0;
                                state_next     = ST_RESP;
                            end else begin
                                poll_cnt_next = poll_cnt_inc;
                                op_start      = 1'b1;
                            end
                        end
                        ST_IRQ_CLR: begin
                            op_start   = 1'b1;
                            op_addr    = REG_RX0;
                            state_next = ST_RD_RX;
                        end
                        ST_RD_RX: begin
                            rsp_data_next  = op_rdata;
                            rsp_err_next   = 1'b0;
                            rsp_valid_next = 1'b1;
                            state_next     = ST_RESP;
                        end
                        default: state_next = ST_IDLE_CFG;
                    endcase
                end
            end
        endcase
    end

endmodule
